// File: rtl/eigen_sequencer.sv
// eigen_sequencer: multi-eigenpair controller that drives an external single-pair eigen engine.
// Optional feature macro EIG_SORT_EN keeps stored pairs ordered by descending |lambda|.
package fp_double;
    typedef logic [63:0] double_t;
endpackage

module eigen_sequencer
    import fp_double::*;
#(
    parameter int          SIZE_N      = 8,
    parameter int          NUM_EIG     = 4,
    parameter int          TIMEOUT_CYC = 4096,
    parameter logic [10:0] MIN_EXP     = 11'd1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  double_t                        cov_matrix     [SIZE_N][SIZE_N],
    output logic                           eig_start,
    output double_t                        eig_matrix     [SIZE_N][SIZE_N],
    input  logic                           eig_done,
    input  double_t                        eig_value,
    input  double_t                        eig_vector     [SIZE_N],
    input  double_t                        eig_matrix_upd [SIZE_N][SIZE_N],
    output double_t                        eigenvalues    [NUM_EIG],
    output double_t                        eigenvectors   [NUM_EIG][SIZE_N],
    output logic [$clog2(NUM_EIG+1)-1:0]   num_found,
    output logic                           busy,
    output logic                           done,
    output logic                           err_timeout
);

    localparam int NFW = $clog2(NUM_EIG + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [NFW-1:0] LAST_SLOT = NFW'(NUM_EIG - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_STORE, S_DONE} state_t;

    state_t          r_state, w_next;
    double_t         r_work     [SIZE_N][SIZE_N];
    double_t         r_hold_mat [SIZE_N][SIZE_N];
    double_t         r_hold_vec [SIZE_N];
    double_t         r_hold_val;
    double_t         r_ev       [NUM_EIG];
    double_t         r_evec     [NUM_EIG][SIZE_N];
    logic [NFW-1:0]  r_num_found;
    logic [WDW-1:0]  r_wdog;
    logic            r_err;
    logic            w_small, w_last, w_expire;
    logic [NFW-1:0]  w_pos;

    assign w_small  = r_hold_val[62:52] < MIN_EXP;
    assign w_last   = r_num_found == LAST_SLOT;
    assign w_expire = r_wdog == WD_LAST;

`ifdef EIG_SORT_EN
    // First occupied slot holding a strictly smaller magnitude; ties land after existing entries.
    always_comb begin
        w_pos = r_num_found;
        for (int i = NUM_EIG - 1; i >= 0; i--) begin
            if (NFW'(i) < r_num_found && r_hold_val[62:0] > r_ev[i][62:0])
                w_pos = NFW'(i);
        end
    end
`else
    assign w_pos = r_num_found;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (eig_done)      w_next = S_STORE;
                else if (w_expire) w_next = S_DONE;
            end
            S_STORE:  w_next = (w_small || w_last) ? S_DONE : S_LAUNCH;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        eig_start = (r_state == S_LAUNCH);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_found <= '0;
            r_wdog      <= '0;
            r_err       <= 1'b0;
            r_hold_val  <= '0;
            for (int unsigned i = 0; i < SIZE_N; i++) begin
                r_hold_vec[i] <= '0;
                for (int unsigned j = 0; j < SIZE_N; j++) begin
                    r_work[i][j]     <= '0;
                    r_hold_mat[i][j] <= '0;
                end
            end
            for (int unsigned k = 0; k < NUM_EIG; k++) begin
                r_ev[k] <= '0;
                for (int unsigned j = 0; j < SIZE_N; j++) r_evec[k][j] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_work      <= cov_matrix;
                    r_num_found <= '0;
                    r_err       <= 1'b0;
                    for (int unsigned k = 0; k < NUM_EIG; k++) begin
                        r_ev[k] <= '0;
                        for (int unsigned j = 0; j < SIZE_N; j++) r_evec[k][j] <= '0;
                    end
                end
                S_LAUNCH: r_wdog <= '0;
                S_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (eig_done) begin
                        r_hold_val <= eig_value;
                        r_hold_vec <= eig_vector;
                        r_hold_mat <= eig_matrix_upd;
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                    end
                end
                S_STORE: begin
                    if (!w_small) begin
                        // Shift occupied slots above the insertion point up by one, then drop the pair in.
                        for (int unsigned k = 1; k < NUM_EIG; k++) begin
                            if (NFW'(k) > w_pos && NFW'(k) <= r_num_found) begin
                                r_ev[k]   <= r_ev[k-1];
                                r_evec[k] <= r_evec[k-1];
                            end
                        end
                        for (int unsigned k = 0; k < NUM_EIG; k++) begin
                            if (NFW'(k) == w_pos) begin
                                r_ev[k]   <= r_hold_val;
                                r_evec[k] <= r_hold_vec;
                            end
                        end
                        r_work      <= r_hold_mat;
                        r_num_found <= r_num_found + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eig_matrix   = r_work;
    assign eigenvalues  = r_ev;
    assign eigenvectors = r_evec;
    assign num_found    = r_num_found;
    assign err_timeout  = r_err;

endmodule
